loop_index_sequencer: RTL and testbench

Clocked index generator that sweeps an index from a programmable start value up to a fixed limit, one index per accepted handshake beat. It drives the index/done signal pair that the loop_if interface carries. It sits directly upstream of the combinational while-loop consumer and replaces its in-one-cycle sweep with a registered, back-pressurable sequence plus a completion pulse.

---
 rtl/loop_index_sequencer.sv | 146 ++++++++++++++
 tb/tb_loop_index_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_index_sequencer.sv
// loop_index_sequencer
// Registered, back-pressurable index sweep from start_index up to LIMIT-1.
// Each accepted handshake beat (idx_valid && idx_ready) advances the index.
// When the sweep completes, done pulses for one cycle. An abort in RUN returns
// the block to IDLE and pulses aborted for one cycle.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   start        request a sweep (sampled only in IDLE)
//   start_index  first index of the sweep (sampled with start)
//   abort        cancel the sweep (honoured only in RUN)
//   idx_ready    downstream accepts the current index
//   idx_valid    index is valid
//   index        current index (loop_if.index)
//   done         one-cycle completion pulse (loop_if.done)
//   aborted      one-cycle abort pulse
//   busy         block is not idle
//   iter_count   beats accepted in the current or most recent sweep
module loop_index_sequencer #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned LIMIT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] start_index,
    input  logic             abort,
    input  logic             idx_ready,
    output logic             idx_valid,
    output logic [IDX_W-1:0] index,
    output logic             done,
    output logic             aborted,
    output logic             busy,
    output logic [IDX_W:0]   iter_count
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LIMIT_IDX = IDX_W'(LIMIT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] index_n;
    logic [CNT_W-1:0] iter_n;
    logic             valid_n;
    logic             done_n;
    logic             aborted_n;
    logic             busy_n;

    logic             beat_c;
    logic             last_c;

    assign beat_c = idx_valid && idx_ready;
    assign last_c = (index == LAST_IDX);

    // State and output registers; every output is a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            index      <= '0;
            iter_count <= '0;
            idx_valid  <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            index      <= index_n;
            iter_count <= iter_n;
            idx_valid  <= valid_n;
            done       <= done_n;
            aborted    <= aborted_n;
            busy       <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        index_n   = index;
        iter_n    = iter_count;
        valid_n   = idx_valid;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        busy_n    = busy;

        unique case (state)
            ST_IDLE: begin
                busy_n  = 1'b0;
                valid_n = 1'b0;
                if (start) begin
                    index_n = start_index;
                    iter_n  = '0;
                    busy_n  = 1'b1;
                    if (start_index < LIMIT_IDX) begin
                        state_n = ST_RUN;
                        valid_n = 1'b1;
                    end else begin
                        // Empty loop: go straight to the completion cycle.
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (beat_c) begin
                    iter_n = iter_count + CNT_W'(1);
                end
                // Completion takes priority over a simultaneous abort.
                if (beat_c && last_c) begin
                    state_n = ST_DONE;
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                end else if (abort) begin
                    state_n   = ST_IDLE;
                    valid_n   = 1'b0;
                    aborted_n = 1'b1;
                    busy_n    = 1'b0;
                end else if (beat_c) begin
                    index_n = index + IDX_W'(1);
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_loop_index_sequencer.sv
// Testbench for loop_index_sequencer: directed scenarios plus random stimulus.
// Every cycle is compared against a sweep-level reference model, which counts
// the beats remaining in the current sweep.
module tb_loop_index_sequencer;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned LIMIT = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W-1:0] start_index = '0;
    logic             abort = 1'b0;
    logic             idx_ready = 1'b0;
    logic             idx_valid;
    logic [IDX_W-1:0] index;
    logic             done;
    logic             aborted;
    logic             busy;
    logic [IDX_W:0]   iter_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: what the outputs should be after the most recent edge.
    bit m_valid   = 1'b0;
    bit m_busy    = 1'b0;
    bit m_done    = 1'b0;
    bit m_aborted = 1'b0;
    int m_index   = 0;
    int m_count   = 0;
    int m_left    = 0;

    loop_index_sequencer #(.IDX_W(IDX_W), .LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_index (start_index),
        .abort       (abort),
        .idx_ready   (idx_ready),
        .idx_valid   (idx_valid),
        .index       (index),
        .done        (done),
        .aborted     (aborted),
        .busy        (busy),
        .iter_count  (iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs currently driven.
    task automatic model_step();
        bit was_done;
        if (!rst_n) begin
            m_valid = 0; m_busy = 0; m_done = 0; m_aborted = 0;
            m_index = 0; m_count = 0; m_left = 0;
            return;
        end
        was_done  = m_done;
        m_done    = 0;
        m_aborted = 0;
        if (m_valid) begin
            if (idx_ready) begin
                m_count++;
                m_left--;
            end
            if (idx_ready && m_left == 0) begin
                m_valid = 0;
                m_done  = 1;
            end else if (abort) begin
                m_valid   = 0;
                m_aborted = 1;
                m_busy    = 0;
            end else if (idx_ready) begin
                m_index++;
            end
        end else if (was_done) begin
            m_busy = 0;
        end else if (!m_busy && start) begin
            m_index = int'(start_index);
            m_count = 0;
            m_busy  = 1;
            if (int'(start_index) < int'(LIMIT)) begin
                m_valid = 1;
                m_left  = int'(LIMIT) - int'(start_index);
            end else begin
                m_done = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, clock, then compare all outputs against the model.
    task automatic cycle(input bit r, input bit s, input int si, input bit a, input bit rdy);
        rst_n       = r;
        start       = s;
        start_index = IDX_W'(si);
        abort       = a;
        idx_ready   = rdy;
        @(posedge clk);
        model_step();
        #1;
        check("idx_valid",  32'(idx_valid),  32'(m_valid));
        check("index",      32'(index),      m_index);
        check("done",       32'(done),       32'(m_done));
        check("aborted",    32'(aborted),    32'(m_aborted));
        check("busy",       32'(busy),       32'(m_busy));
        check("iter_count", 32'(iter_count), m_count);
        check("done_and_aborted", 32'(done & aborted), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset with random inputs on the other pins.
        for (int i = 0; i < 2; i++)
            cycle(0, 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        check("reset_index", 32'(index), 32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        idle(1);

        // Normal sweep from 7: indices 7, 8, 9, then done.
        cycle(1, 1, 7, 0, 1);
        check("normal_first_index", 32'(index), 32'd7);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);
        check("normal_done", 32'(done), 32'd1);
        check("normal_iter", 32'(iter_count), 32'd3);
        cycle(1, 0, 0, 0, 1);
        check("normal_busy_low", 32'(busy), 32'd0);
        idle(1);

        // Empty loops at 12 and at exactly LIMIT.
        cycle(1, 1, 12, 0, 1);
        check("empty12_done", 32'(done), 32'd1);
        check("empty12_valid", 32'(idx_valid), 32'd0);
        idle(2);
        cycle(1, 1, 10, 0, 1);
        check("empty10_done", 32'(done), 32'd1);
        check("empty10_iter", 32'(iter_count), 32'd0);
        idle(2);

        // Backpressure in cycles 2-3.
        cycle(1, 1, 7, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("bp_hold_index", 32'(index), 32'd8);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        check("bp_done", 32'(done), 32'd1);
        check("bp_iter", 32'(iter_count), 32'd3);
        idle(2);

        // Abort in cycle 4 of a sweep from 0; the beat in that cycle counts.
        cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 1, 1);
        check("abort_pulse", 32'(aborted), 32'd1);
        check("abort_iter", 32'(iter_count), 32'd4);
        check("abort_busy", 32'(busy), 32'd0);
        idle(3);

        // start pulsed during RUN has no effect.
        cycle(1, 1, 5, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1);
        idle(2);

        // Abort together with the final beat: completion wins.
        cycle(1, 1, 7, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 1, 1);
        check("abort_last_done", 32'(done), 32'd1);
        check("abort_last_aborted", 32'(aborted), 32'd0);
        idle(2);

        // Reset in the middle of a sweep.
        cycle(1, 1, 2, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("midrst_index", 32'(index), 32'd0);
        check("midrst_valid", 32'(idx_valid), 32'd0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
